ifu_fetch: RTL and testbench

IFU_FETCH -- requirements
Module: ifu_fetch

---
 rtl/ifu_fetch.sv | 167 ++++++++++++++++
 tb/tb_ifu_fetch.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch -- single-outstanding instruction fetch unit.
//
// Fetches one word at a time from instruction memory and presents it to
// decode over a valid/ready handshake. Redirects (branch/jump/trap) override
// the fetch PC at any point. An in-flight response that belongs to a
// superseded PC is discarded. A WAIT timeout forces a faulting delivery.
//
// Parameters:
//   RESET_PC        first fetch address after reset
//   TIMEOUT_CYCLES  maximum cycles spent in WAIT before a fault is forced
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   mem_req/mem_addr/mem_gnt    request channel to instruction memory
//   mem_rvalid/mem_rdata/mem_err response channel (one beat per grant)
//   redirect_valid/redirect_pc  next-PC override
//   inst_valid/inst_ready       handshake to decode
//   inst/inst_pc/inst_fault     delivered word, its PC, fault flag
//
// Build option:
//   IFU_MISALIGN_TRAP_EN  when defined, a redirect to a non-word-aligned PC
//                         skips memory and delivers a faulting instruction
//                         at that PC. When undefined, the low two bits of the
//                         redirect PC are cleared and fetch proceeds normally.

module ifu_fetch #(
   parameter logic [31:0] RESET_PC       = 32'h8000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   input  logic        mem_err,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_fault
);

   typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT, S_HOLD} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        drop_q, drop_d;
   // An accepted request whose response was abandoned (timeout) is still
   // on its way; the next mem_rvalid belongs to it and must not be consumed.
   logic        stale_q, stale_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic        inst_fault_q, inst_fault_d;

   logic [31:0] redir_pc;
   logic        rsp_take;
   logic        timeout;

   assign redir_pc = redirect_pc & 32'hFFFF_FFFC;
   assign rsp_take = mem_rvalid && !stale_q;
   assign timeout  = (cnt_q == TIMEOUT_CYCLES - 32'd1);

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      drop_d       = drop_q;
      stale_d      = stale_q && !mem_rvalid;
      cnt_d        = cnt_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      inst_fault_d = inst_fault_q;

      case (state_q)
         S_BOOT: begin
            if (redirect_valid) pc_d = redir_pc;
            state_d = S_REQ;
         end
         S_REQ: begin
            if (redirect_valid) pc_d = redir_pc;
            if (mem_gnt) begin
               // Granted for the old PC; a coincident redirect marks it dead.
               state_d = S_WAIT;
               cnt_d   = '0;
               drop_d  = redirect_valid;
            end
         end
         S_WAIT: begin
            if (redirect_valid) begin
               pc_d   = redir_pc;
               drop_d = 1'b1;
            end
            if (rsp_take || timeout) begin
               drop_d = 1'b0;
               if (!rsp_take) stale_d = 1'b1;
               if (drop_q || redirect_valid) begin
                  state_d = S_REQ;
               end else begin
                  state_d      = S_HOLD;
                  inst_pc_d    = pc_q;
                  inst_d       = rsp_take ? mem_rdata : '0;
                  inst_fault_d = rsp_take ? mem_err : 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         S_HOLD: begin
            if (redirect_valid) begin
               pc_d    = redir_pc;
               state_d = S_REQ;
            end else if (inst_ready) begin
               pc_d    = pc_q + 32'd4;
               state_d = S_REQ;
            end
         end
         default: state_d = S_BOOT;
      endcase

`ifdef IFU_MISALIGN_TRAP_EN
      if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
         state_d      = S_HOLD;
         pc_d         = redir_pc;
         drop_d       = 1'b0;
         inst_d       = '0;
         inst_pc_d    = redirect_pc;
         inst_fault_d = 1'b1;
         if ((state_q == S_REQ && mem_gnt) || (state_q == S_WAIT && !rsp_take))
            stale_d = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_BOOT;
         pc_q         <= RESET_PC;
         drop_q       <= 1'b0;
         stale_q      <= 1'b0;
         cnt_q        <= '0;
         inst_q       <= '0;
         inst_pc_q    <= '0;
         inst_fault_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         drop_q       <= drop_d;
         stale_q      <= stale_d;
         cnt_q        <= cnt_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
         inst_fault_q <= inst_fault_d;
      end
   end

   assign mem_req    = (state_q == S_REQ);
   assign mem_addr   = pc_q;
   assign inst_valid = (state_q == S_HOLD);
   assign inst       = inst_q;
   assign inst_pc    = inst_pc_q;
   assign inst_fault = inst_fault_q;

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

   localparam int unsigned TO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        mem_err;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_fault;

   int unsigned checks = 0;
   int unsigned errors = 0;

   // memory responder settings
   logic        rsp_en;
   int unsigned rsp_delay;
   int unsigned rsp_left;
   logic [31:0] rsp_data;
   logic        rsp_err;

   ifu_fetch #(
      .RESET_PC       (32'h8000_0000),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_gnt        (mem_gnt),
      .mem_rvalid     (mem_rvalid),
      .mem_rdata      (mem_rdata),
      .mem_err        (mem_err),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_fault     (inst_fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One clock: responder answers rsp_delay cycles after a grant.
   task automatic step();
      logic acc;
      acc = mem_req && mem_gnt;
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      mem_err    = 1'b0;
      if (acc && rsp_en) rsp_left = rsp_delay;
      if (rsp_left > 0) begin
         rsp_left--;
         if (rsp_left == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rsp_data;
            mem_err    = rsp_err;
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
      rsp_en = 1'b1; rsp_delay = 1; rsp_left = 0; rsp_data = 32'h0000_0013; rsp_err = 1'b0;

      @(posedge clk); #1;
      chk("rst_req",   32'(mem_req),    32'h0);
      chk("rst_addr",  mem_addr,        32'h8000_0000);
      chk("rst_valid", 32'(inst_valid), 32'h0);
      chk("rst_inst",  inst,            32'h0);
      chk("rst_pc",    inst_pc,         32'h0);
      chk("rst_fault", 32'(inst_fault), 32'h0);
      rst = 1'b0;
      chk("boot_req",  32'(mem_req),    32'h0);

      // streaming: one instruction every 3 cycles
      for (int i = 0; i < 3; i++) begin
         step();
         chk("seq_req",   32'(mem_req), 32'h1);
         chk("seq_addr",  mem_addr,     32'h8000_0000 + 32'(4 * i));
         step();
         chk("seq_wait",  32'(mem_req | inst_valid), 32'h0);
         step();
         chk("seq_valid", 32'(inst_valid), 32'h1);
         chk("seq_pc",    inst_pc,         32'h8000_0000 + 32'(4 * i));
         chk("seq_inst",  inst,            32'h0000_0013);
      end

      // decode stall in HOLD
      inst_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_valid", 32'(inst_valid), 32'h1);
         chk("stall_pc",    inst_pc,         32'h8000_0008);
         chk("stall_req",   32'(mem_req),    32'h0);
      end
      inst_ready = 1'b1;
      step();
      chk("stall_next", mem_addr, 32'h8000_000C);
      chk("stall_vld0", 32'(inst_valid), 32'h0);

      // redirect while WAITing: response dropped
      rsp_delay = 3;
      step();                                  // WAIT for 8000_000C
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
      step();
      redirect_valid = 1'b0;
      chk("drop_wait", 32'(inst_valid), 32'h0);
      step();                                  // dropped response present
      chk("drop_rsp",  32'(inst_valid), 32'h0);
      step();
      chk("drop_valid", 32'(inst_valid), 32'h0);
      chk("drop_addr",  mem_addr,        32'h8000_0100);
      chk("drop_req",   32'(mem_req),    32'h1);
      rsp_delay = 1;
      step(); step();
      chk("redir_valid", 32'(inst_valid), 32'h1);
      chk("redir_pc",    inst_pc,         32'h8000_0100);

      // grant back-pressure, then error response
      mem_gnt = 1'b0;
      step();
      chk("gnt0_addr", mem_addr, 32'h8000_0104);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("gnt0_req",  32'(mem_req), 32'h1);
         chk("gnt0_hold", mem_addr,     32'h8000_0104);
      end
      mem_gnt = 1'b1; rsp_err = 1'b1;
      step(); step();
      rsp_err = 1'b0;
      chk("err_valid", 32'(inst_valid), 32'h1);
      chk("err_fault", 32'(inst_fault), 32'h1);
      chk("err_pc",    inst_pc,         32'h8000_0104);

      // redirect in HOLD with coincident handshake: redirect wins the PC
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
      step();
      redirect_valid = 1'b0;
      chk("hredir_valid", 32'(inst_valid), 32'h0);
      chk("hredir_addr",  mem_addr,        32'h8000_0200);

      // timeout: exactly TO cycles in WAIT
      rsp_en = 1'b0;
      step();
      for (int i = 0; i < int'(TO) - 1; i++) begin
         step();
         chk("to_wait", 32'(inst_valid | mem_req), 32'h0);
      end
      step();
      chk("to_valid", 32'(inst_valid), 32'h1);
      chk("to_inst",  inst,            32'h0);
      chk("to_fault", 32'(inst_fault), 32'h1);
      chk("to_pc",    inst_pc,         32'h8000_0200);
      inst_ready = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      step();
      chk("late_inst",  inst,            32'h0);
      chk("late_valid", 32'(inst_valid), 32'h1);
      inst_ready = 1'b1; rsp_en = 1'b1;
      step();
      chk("post_to_addr", mem_addr, 32'h8000_0204);
      step(); step();
      chk("post_to_inst",  inst,            32'h0000_0013);
      chk("post_to_fault", 32'(inst_fault), 32'h0);
      chk("post_to_pc",    inst_pc,         32'h8000_0204);

      // misaligned redirect
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
      step();
      redirect_valid = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
      chk("mis_req",   32'(mem_req),    32'h0);
      chk("mis_fault", 32'(inst_fault), 32'h1);
      chk("mis_pc",    inst_pc,         32'h8000_0102);
`else
      chk("mis_req",   32'(mem_req),    32'h1);
      chk("mis_addr",  mem_addr,        32'h8000_0100);
`endif

      // reset mid-flight, then redirect in BOOT
      step();
      rst = 1'b1;
      #2;
      chk("arst_req",   32'(mem_req),    32'h0);
      chk("arst_addr",  mem_addr,        32'h8000_0000);
      chk("arst_valid", 32'(inst_valid), 32'h0);
      chk("arst_pc",    inst_pc,         32'h0);
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0300;
      @(posedge clk); #1;
      rst = 1'b0; mem_rvalid = 1'b0; rsp_left = 0;
      step();
      redirect_valid = 1'b0;
      chk("boot_redir", mem_addr, 32'h8000_0300);

      // back-to-back redirects in REQ without grant: last one wins
      mem_gnt = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0400;
      step();
      chk("b2b_a", mem_addr, 32'h8000_0400);
      redirect_pc = 32'h8000_0500;
      step();
      redirect_valid = 1'b0;
      chk("b2b_b", mem_addr, 32'h8000_0500);
      mem_gnt = 1'b1;
      step(); step();
      chk("b2b_valid", 32'(inst_valid), 32'h1);
      chk("b2b_pc",    inst_pc,         32'h8000_0500);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
